// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode.
// Circular FIFO of {pc, inst, compressed} with valid/ready on both sides.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_compressed,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_compressed,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [31:0]     inst_q [DEPTH];
  logic            comp_q [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                 (rd_ptr[AW] != wr_ptr[AW]);

  // in_ready looks at state only, so a full queue never takes a push
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign level     = wr_ptr - rd_ptr;

  // Pointer update; flush invalidates everything by catching rd up to wr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry storage; contents are never cleared, only the pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr[AW-1:0]]   <= in_pc;
      inst_q[wr_ptr[AW-1:0]] <= in_inst;
      comp_q[wr_ptr[AW-1:0]] <= in_compressed;
    end
  end

  // Head read; zero when empty, upper half masked for RVC
  always_comb begin
    out_pc         = '0;
    out_inst       = '0;
    out_compressed = 1'b0;
    if (!empty) begin
      out_pc         = pc_q[rd_ptr[AW-1:0]];
      out_compressed = comp_q[rd_ptr[AW-1:0]];
      out_inst       = inst_q[rd_ptr[AW-1:0]];
      if (out_compressed) out_inst[31:16] = 16'h0;
    end
  end

endmodule
